// File: rtl/boolexp_pkg.sv
// Shared definitions for the boolexp family of truth-table evaluators.
//   TT_W        : width of a 3-input truth table (one bit per minterm)
//   IDX_W       : width of a minterm index {a,b,c}
//   BOOLEXP1_TT : default function (a & b) | (~a & c)
package boolexp_pkg;

  localparam int unsigned IDX_W = 3;
  localparam int unsigned TT_W  = 8;

  localparam logic [TT_W-1:0] BOOLEXP1_TT = 8'hCA;

  typedef logic [IDX_W-1:0] minterm_t;

endpackage : boolexp_pkg

// File: rtl/boolexp1_eval_if.sv
// Operand/result bundle for boolexp1_eval.
//   in_valid, a, b, c : operands and strobe from upstream
//   y, out_valid      : registered result and its valid
//   minterm           : registered {a,b,c} index that produced y
// master = upstream/observer side, slave = evaluator side.
interface boolexp1_eval_if;
  import boolexp_pkg::*;

  logic     in_valid;
  logic     a;
  logic     b;
  logic     c;
  logic     y;
  logic     out_valid;
  minterm_t minterm;

  modport master (
    output in_valid, a, b, c,
    input  y, out_valid, minterm
  );

  modport slave (
    input  in_valid, a, b, c,
    output y, out_valid, minterm
  );

endinterface : boolexp1_eval_if

// File: rtl/tt_lookup3.sv
// Combinational 3-input truth-table lookup.
//   idx : minterm index {a,b,c}
//   f   : TRUTH_TABLE[idx]
module tt_lookup3
  import boolexp_pkg::*;
#(
  parameter logic [TT_W-1:0] TRUTH_TABLE = BOOLEXP1_TT
) (
  input  minterm_t idx,
  output logic     f
);

  assign f = TRUTH_TABLE[idx];

endmodule : tt_lookup3

// File: rtl/boolexp1_eval.sv
// Registered 3-input Boolean function evaluator, one-cycle latency,
// accepts a new operand set every cycle (no backpressure).
//   clk : rising-edge clock
//   rst : synchronous active-high reset, dominates in_valid
//   bus : boolexp1_eval_if.slave (operands in, registered result out)
module boolexp1_eval
  import boolexp_pkg::*;
#(
  parameter logic [TT_W-1:0] TRUTH_TABLE = BOOLEXP1_TT
) (
  input logic                clk,
  input logic                rst,
  boolexp1_eval_if.slave     bus
);

  minterm_t idx_c;
  logic     f_c;

  logic     y_q;
  logic     out_valid_q;
  minterm_t minterm_q;

  assign idx_c = {bus.a, bus.b, bus.c};

  tt_lookup3 #(
    .TRUTH_TABLE (TRUTH_TABLE)
  ) u_tt (
    .idx (idx_c),
    .f   (f_c)
  );

  // Result/index only load on accepted inputs, so operand garbage while
  // idle never reaches the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q         <= 1'b0;
      out_valid_q <= 1'b0;
      minterm_q   <= '0;
    end else if (bus.in_valid) begin
      y_q         <= f_c;
      out_valid_q <= 1'b1;
      minterm_q   <= idx_c;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.y         = y_q;
  assign bus.out_valid = out_valid_q;
  assign bus.minterm   = minterm_q;

endmodule : boolexp1_eval

// File: tb/tb_boolexp1_eval.sv
// Self-checking bench: default-table (mux) and XOR-table instances share
// stimulus and are compared every cycle against a Boolean reference model.
module tb_boolexp1_eval;

  logic clk;
  logic rst;

  boolexp1_eval_if bus_mux ();
  boolexp1_eval_if bus_xor ();

  boolexp1_eval u_dut_mux (
    .clk (clk),
    .rst (rst),
    .bus (bus_mux.slave)
  );

  boolexp1_eval #(
    .TRUTH_TABLE (8'h96)
  ) u_dut_xor (
    .clk (clk),
    .rst (rst),
    .bus (bus_xor.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk;
  int unsigned n_pass;

  // Reference state, one set per instance.
  logic       exp_mux_y, exp_mux_v;
  logic [2:0] exp_mux_m;
  logic       exp_xor_y, exp_xor_v;
  logic [2:0] exp_xor_m;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic cyc(input logic r, input logic v, input logic ia, input logic ib, input logic ic);
    rst = r;
    bus_mux.in_valid = v; bus_mux.a = ia; bus_mux.b = ib; bus_mux.c = ic;
    bus_xor.in_valid = v; bus_xor.a = ia; bus_xor.b = ib; bus_xor.c = ic;
    @(posedge clk);
    #1;
    if (r) begin
      exp_mux_y = 1'b0; exp_mux_v = 1'b0; exp_mux_m = 3'd0;
      exp_xor_y = 1'b0; exp_xor_v = 1'b0; exp_xor_m = 3'd0;
    end else if (v) begin
      exp_mux_y = ia ? ib : ic;
      exp_mux_v = 1'b1;
      exp_mux_m = {ia, ib, ic};
      exp_xor_y = ia ^ ib ^ ic;
      exp_xor_v = 1'b1;
      exp_xor_m = {ia, ib, ic};
    end else begin
      exp_mux_v = 1'b0;
      exp_xor_v = 1'b0;
    end
    check("mux_y",       8'(bus_mux.y),         8'(exp_mux_y));
    check("mux_valid",   8'(bus_mux.out_valid), 8'(exp_mux_v));
    check("mux_minterm", 8'(bus_mux.minterm),   8'(exp_mux_m));
    check("xor_y",       8'(bus_xor.y),         8'(exp_xor_y));
    check("xor_valid",   8'(bus_xor.out_valid), 8'(exp_xor_v));
    check("xor_minterm", 8'(bus_xor.minterm),   8'(exp_xor_m));
  endtask

  initial begin
    logic [2:0] idx;
    logic [7:0] mux_seq;
    logic [7:0] xor_seq;
    n_chk  = 0;
    n_pass = 0;
    mux_seq = 8'b1100_1010;  // y for idx 7..0 = 1,1,0,0,1,0,1,0
    xor_seq = 8'b1001_0110;

    // Reset held with a valid 111 presented: reset must win.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    // Exhaustive sweep, with literal expectations on top of the model.
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      cyc(1'b0, 1'b1, idx[2], idx[1], idx[0]);
      check("sweep_mux_lit", 8'(bus_mux.y), 8'(mux_seq[i]));
      check("sweep_xor_lit", 8'(bus_xor.y), 8'(xor_seq[i]));
    end

    // Hold: 110 then three idle cycles with toggling operands.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      check("hold_y_lit",   8'(bus_mux.y),       8'd1);
      check("hold_idx_lit", 8'(bus_mux.minterm), 8'd6);
    end

    // Reset mid-stream: 011, 111, then reset while 101 is presented.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("midrst_idx_lit", 8'(bus_mux.minterm), 8'd0);
    // First valid after reset release appears one cycle later.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("post_rst_y_lit", 8'(bus_mux.y), 8'd1);

    // Randomized traffic with occasional reset and idle cycles.
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
          1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_boolexp1_eval

// File: doc/boolexp1_eval.md
Name: boolexp1_eval

Overview:
- Registered three-input Boolean function evaluator: y = (a & b) | (~a & c), i.e. a selects b when 1 and c when 0.
- Function is held as an 8-entry truth-table parameter, so the same block can realise any 3-input function.
- Sits as a leaf datapath cell. Upstream drives a, b, c with a valid strobe; downstream samples y with a matching valid.

Parameters:
- TRUTH_TABLE, 8'hCA: bit i gives y for minterm index i = {a,b,c}. The default 8'hCA encodes (a & b) | (~a & c).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a, b, c are valid this cycle.
- a  input  1  operand a, minterm index bit 2 (MSB).
- b  input  1  operand b, minterm index bit 1.
- c  input  1  operand c, minterm index bit 0 (LSB).
- y  output  1  registered function result.
- out_valid  output  1  y corresponds to an accepted input.
- minterm  output  3  registered {a,b,c} index that produced y, for debug and coverage.

Behaviour:
- Reset: on a rising clk edge with rst=1, set y=0, out_valid=0, minterm=3'b000. rst has priority over in_valid in the same cycle.
- Evaluation is combinational: idx = {a,b,c}; f = TRUTH_TABLE[idx].
- Latency is 1 cycle. If in_valid=1 at edge N, then after edge N: y=f, minterm=idx, out_valid=1.
- If in_valid=0 at an edge, out_valid goes to 0, and y and minterm hold their previous values.
- Back-to-back inputs are accepted every cycle. There is no backpressure and no ready signal.
- All outputs come directly from flops; there is no combinational path from inputs to outputs.
- X on a, b or c while in_valid=0 must not propagate to y or minterm.
- Deasserting reset resumes normal operation on the next edge. The first valid output appears one cycle after the first in_valid=1 sampled with rst=0.
- Truth table for the default TRUTH_TABLE, indexed by {a,b,c}:
  - 000→0, 001→1, 010→0, 011→1
  - 100→0, 101→0, 110→1, 111→1

Decomposition:
- Shared package boolexp_pkg holds:
  - localparam BOOLEXP1_TT = 8'hCA;
  - typedef logic [2:0] minterm_t.
- One optional sub-module, tt_lookup3: purely combinational, parameter TRUTH_TABLE, input idx[2:0], output f. Instantiated once.
- Top level holds only the registers and valid tracking.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 and a=b=c=1 → y=0, out_valid=0, minterm=000 throughout.
- Exhaustive sweep: in_valid=1, apply idx 000..111 on consecutive cycles → one cycle later, y sequence is 0,1,0,1,0,0,1,1 and minterm echoes 0..7 with out_valid=1 every cycle.
- Hold: apply 110 with in_valid=1, then in_valid=0 for 3 cycles while toggling a, b, c → y stays 1, minterm stays 110, out_valid=0 during the hold cycles.
- Reset mid-stream: stream 011, 111; assert rst on the cycle 101 is presented → y=0, out_valid=0 after that edge; 101 is not reflected.
- Alternate table: instantiate with TRUTH_TABLE=8'h96 (3-input XOR) and sweep 000..111 → y = 0,1,1,0,1,0,0,1.
- Reset vs valid priority: rst=1 and in_valid=1 with input 111 in the same cycle → out_valid=0, y=0 after the edge.
